// File: rtl/writeback_stage_if.sv
// EX_WB retire bus, decoder read ports and commit trace between execute, decoder and writeback.
// The master side drives the retire bus and read addresses; the slave is the writeback stage.
interface writeback_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned BUS_W  = 71,
  parameter int unsigned AW     = 5
);
  logic [BUS_W-1:0]  ex_wb;
  logic              wb_ready;
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              commit_valid;
  logic [AW-1:0]     commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [31:0]       commit_pc;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output ex_wb, rs1_addr, rs2_addr,
    input  wb_ready, rs1_data, rs2_data, commit_valid, commit_rd, commit_data, commit_pc,
           retire_count
  );

  modport slave (
    input  ex_wb, rs1_addr, rs2_addr,
    output wb_ready, rs1_data, rs2_data, commit_valid, commit_rd, commit_data, commit_pc,
           retire_count
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: retires EX_WB results into a register file with write-through read ports,
// emits a commit trace and retire counter. The array is cleared by a walk after each reset.
module writeback_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BUS_W  = 71,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  writeback_stage_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);

  typedef enum logic {StClear, StRun} state_e;

  state_e            r_state, w_state_d;
  logic [AW-1:0]     r_clear_idx;
  logic [DATA_W-1:0] r_regs [NREGS];

  logic              w_valid, w_reg_write, w_run, w_retire, w_bypass;
  logic [AW-1:0]     w_rd;
  logic [DATA_W-1:0] w_result;
  logic [31:0]       w_pc;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdata;

  logic              r_commit_valid;
  logic [AW-1:0]     r_commit_rd;
  logic [DATA_W-1:0] r_commit_data;
  logic [31:0]       r_commit_pc;
  logic [CNT_W-1:0]  r_retire_count;

  assign w_valid     = bus.ex_wb[BUS_W-1];
  assign w_reg_write = bus.ex_wb[BUS_W-2];
  assign w_rd        = bus.ex_wb[BUS_W-3 -: AW];
  assign w_result    = bus.ex_wb[32 +: DATA_W];
  assign w_pc        = bus.ex_wb[31:0];

  assign w_run    = (r_state == StRun);
  assign w_retire = w_run && w_valid;
  assign w_bypass = w_retire && w_reg_write;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StClear: if (r_clear_idx == AW'(NREGS - 1)) w_state_d = StRun;
      StRun:   w_state_d = StRun;
      default: w_state_d = StClear;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StClear;
      r_clear_idx <= '0;
    end else begin
      r_state <= w_state_d;
      if (!w_run) r_clear_idx <= r_clear_idx + 1'b1;
    end
  end

  // One write port shared by the clear walk and retirement; r0 is never retired into.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clear_idx;
    w_wdata = '0;
    if (!w_run) begin
      w_we = 1'b1;
    end else if (w_bypass && (w_rd != '0)) begin
      w_we    = 1'b1;
      w_waddr = w_rd;
      w_wdata = w_result;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_we) r_regs[w_waddr] <= w_wdata;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_commit_valid <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_data  <= '0;
      r_commit_pc    <= '0;
      r_retire_count <= '0;
    end else begin
      r_commit_valid <= w_retire;
      if (w_retire) begin
        r_commit_rd    <= w_rd;
        r_commit_data  <= w_result;
        r_commit_pc    <= w_pc;
        r_retire_count <= r_retire_count + 1'b1;
      end
    end
  end

  assign bus.rs1_data = (!w_run || (bus.rs1_addr == '0)) ? '0 :
                        (w_bypass && (w_rd == bus.rs1_addr)) ? w_result : r_regs[bus.rs1_addr];
  assign bus.rs2_data = (!w_run || (bus.rs2_addr == '0)) ? '0 :
                        (w_bypass && (w_rd == bus.rs2_addr)) ? w_result : r_regs[bus.rs2_addr];

  assign bus.wb_ready     = w_run;
  assign bus.commit_valid = r_commit_valid;
  assign bus.commit_rd    = r_commit_rd;
  assign bus.commit_data  = r_commit_data;
  assign bus.commit_pc    = r_commit_pc;
  assign bus.retire_count = r_retire_count;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, reset/clear sequences, counter wrap on a
// narrow-counter instance, and randomized retires checked against an architectural model.
module tb_writeback_stage;
  logic clk;
  logic rst_n;

  writeback_stage_if #(.CNT_W(32)) wb ();
  writeback_stage_if #(.CNT_W(4))  wb4 ();

  assign wb4.ex_wb    = wb.ex_wb;
  assign wb4.rs1_addr = wb.rs1_addr;
  assign wb4.rs2_addr = wb.rs2_addr;

  writeback_stage #(.CNT_W(32)) u_dut (.i_clock(clk), .i_reset(rst_n), .bus(wb));
  writeback_stage #(.CNT_W(4))  u_dut4 (.i_clock(clk), .i_reset(rst_n), .bus(wb4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] mk(input logic v, input logic we, input logic [4:0] rd,
                                     input logic [31:0] res, input logic [31:0] pc);
    return {v, we, rd, res, pc};
  endfunction

  // Architectural model: register values, clear duration and commit trace.
  logic [31:0] m_regs [32];
  int unsigned m_edges;
  logic        m_cv;
  logic [4:0]  m_crd;
  logic [31:0] m_cdata, m_cpc, m_count;

  function automatic bit m_run();
    return m_edges >= 32;
  endfunction

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = '0;
    m_edges = 0;
    m_cv = 0; m_crd = 0; m_cdata = 0; m_cpc = 0; m_count = 0;
  endtask

  task automatic model_edge();
    logic [70:0] b;
    b = wb.ex_wb;
    if (!m_run()) begin
      m_edges++;
    end else if (b[70]) begin
      if (b[69] && b[68:64] != 0) m_regs[b[68:64]] = b[63:32];
      m_cv = 1; m_crd = b[68:64]; m_cdata = b[63:32]; m_cpc = b[31:0];
      m_count = m_count + 1;
    end else begin
      m_cv = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [70:0] b;
    b = wb.ex_wb;
    if (a == 0 || !m_run()) return 0;
    if (b[70] && b[69] && b[68:64] == a) return b[63:32];
    return m_regs[a];
  endfunction

  // Called at posedge+1 after inputs are driven; checks comb outputs then the next edge.
  task automatic step_check(input string tag);
    #1;
    chk({tag, ".ready"}, {31'b0, wb.wb_ready}, {31'b0, m_run()});
    chk({tag, ".rs1"}, wb.rs1_data, model_read(wb.rs1_addr));
    chk({tag, ".rs2"}, wb.rs2_data, model_read(wb.rs2_addr));
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".cv"}, {31'b0, wb.commit_valid}, {31'b0, m_cv});
    chk({tag, ".crd"}, {27'b0, wb.commit_rd}, {27'b0, m_crd});
    chk({tag, ".cdata"}, wb.commit_data, m_cdata);
    chk({tag, ".cpc"}, wb.commit_pc, m_cpc);
    chk({tag, ".cnt"}, wb.retire_count, m_count);
    chk({tag, ".cnt4"}, {28'b0, wb4.retire_count}, {28'b0, m_count[3:0]});
  endtask

  // Reset, then walk the 32-edge clear with a live bus that must be ignored.
  task automatic do_reset();
    rst_n = 1'b0;
    wb.ex_wb = mk(1, 1, 5'd3, 32'h5555_AAAA, 32'h40);
    wb.rs1_addr = 5'd3;
    wb.rs2_addr = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", {31'b0, wb.wb_ready}, 32'd0);
    chk("rst.cv", {31'b0, wb.commit_valid}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      chk("clr.ready", {31'b0, wb.wb_ready}, 32'd0);
      chk("clr.rs1", wb.rs1_data, 32'd0);
      @(posedge clk);
      model_edge();
      #1;
      chk("clr.cnt", wb.retire_count, 32'd0);
    end
    chk("clr.ready_after", {31'b0, wb.wb_ready}, 32'd1);
    chk("clr.cv_after", {31'b0, wb.commit_valid}, 32'd0);
    wb.ex_wb = '0;
  endtask

  typedef struct {
    logic [70:0] bus;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2;
    logic        ecv;
    logic [4:0]  ecrd;
    logic [31:0] ecdata, ecpc, ecnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    rst_n = 1'b1;
    wb.ex_wb = '0;
    wb.rs1_addr = '0;
    wb.rs2_addr = '0;

    tbl[0] = '{mk(1, 1, 5'd5, 32'hDEADBEEF, 32'h100), 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF,
               1'b1, 5'd5, 32'hDEADBEEF, 32'h100, 32'd1};
    tbl[1] = '{mk(0, 0, 5'd0, 32'h0, 32'h0), 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
               1'b0, 5'd5, 32'hDEADBEEF, 32'h100, 32'd1};
    tbl[2] = '{mk(1, 1, 5'd0, 32'h1234, 32'h104), 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
               1'b1, 5'd0, 32'h1234, 32'h104, 32'd2};
    tbl[3] = '{{1'b0, {70{1'b1}}}, 5'd31, 5'd5, 32'h0, 32'hDEADBEEF,
               1'b0, 5'd0, 32'h1234, 32'h104, 32'd2};
    tbl[4] = '{mk(1, 0, 5'd5, 32'hFFFF_FFFF, 32'h108), 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF,
               1'b1, 5'd5, 32'hFFFF_FFFF, 32'h108, 32'd3};
    tbl[5] = '{mk(0, 0, 5'd0, 32'h0, 32'h0), 5'd5, 5'd31, 32'hDEADBEEF, 32'h0,
               1'b0, 5'd5, 32'hFFFF_FFFF, 32'h108, 32'd3};
    tbl[6] = '{mk(1, 1, 5'd31, 32'hCAFEF00D, 32'h10C), 5'd31, 5'd7, 32'hCAFEF00D, 32'h0,
               1'b1, 5'd31, 32'hCAFEF00D, 32'h10C, 32'd4};
    tbl[7] = '{mk(0, 0, 5'd0, 32'h0, 32'h0), 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D,
               1'b0, 5'd31, 32'hCAFEF00D, 32'h10C, 32'd4};

    do_reset();

    foreach (tbl[i]) begin
      wb.ex_wb = tbl[i].bus;
      wb.rs1_addr = tbl[i].a1;
      wb.rs2_addr = tbl[i].a2;
      #1;
      chk($sformatf("tbl%0d.rs1", i), wb.rs1_data, tbl[i].e1);
      chk($sformatf("tbl%0d.rs2", i), wb.rs2_data, tbl[i].e2);
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d.cv", i), {31'b0, wb.commit_valid}, {31'b0, tbl[i].ecv});
      chk($sformatf("tbl%0d.crd", i), {27'b0, wb.commit_rd}, {27'b0, tbl[i].ecrd});
      chk($sformatf("tbl%0d.cdata", i), wb.commit_data, tbl[i].ecdata);
      chk($sformatf("tbl%0d.cpc", i), wb.commit_pc, tbl[i].ecpc);
      chk($sformatf("tbl%0d.cnt", i), wb.retire_count, tbl[i].ecnt);
    end

    // Mid-cycle reset after writing r7: outputs drop at once, r7 is cleared again.
    wb.ex_wb = mk(1, 1, 5'd7, 32'hA5A5_A5A5, 32'h200);
    wb.rs1_addr = 5'd7;
    wb.rs2_addr = 5'd0;
    step_check("r7wr");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.cv", {31'b0, wb.commit_valid}, 32'd0);
    chk("midrst.cnt", wb.retire_count, 32'd0);
    chk("midrst.ready", {31'b0, wb.wb_ready}, 32'd0);
    @(posedge clk);
    #1;
    do_reset();
    wb.rs1_addr = 5'd7;
    #1;
    chk("reclr.r7", wb.rs1_data, 32'd0);
    @(posedge clk);
    #1;

    // Narrow counter: 16 back-to-back retires wrap 15 -> 0.
    for (int i = 0; i < 16; i++) begin
      wb.ex_wb = mk(1, 1, 5'(i), 32'(i * 3), 32'(i * 4));
      @(posedge clk);
      model_edge();
      #1;
      if (i == 14) chk("wrap.cnt15", {28'b0, wb4.retire_count}, 32'd15);
      if (i == 15) chk("wrap.cnt0", {28'b0, wb4.retire_count}, 32'd0);
    end

    // Randomized retires with addresses biased towards the bypassed rd.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb.ex_wb = mk(($urandom_range(0, 9) < 7), $urandom_range(0, 1), rd, $urandom, $urandom);
      wb.rs1_addr = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 7));
      wb.rs2_addr = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      step_check("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
